reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order writeback,
// in-order single-entry commit with branch-mispredict flush.
module reorder_buffer #(
    parameter int ROB_INDEX_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_is_br,
    input  logic                     issue_pred_taken,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_val,
    output logic                     full,
    output logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    input  logic                     wb_valid,
    input  logic [ROB_INDEX_BIT-1:0] wb_rob_id,
    input  logic [31:0]              wb_val,
    input  logic                     wb_taken,
    input  logic [31:0]              wb_target,
    input  logic [ROB_INDEX_BIT-1:0] qry_id1,
    input  logic [ROB_INDEX_BIT-1:0] qry_id2,
    output logic                     qry_ready1,
    output logic [31:0]              qry_val1,
    output logic                     qry_ready2,
    output logic [31:0]              qry_val2,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_val,
    output logic [ROB_INDEX_BIT-1:0] commit_rob_id,
    output logic                     clear,
    output logic [31:0]              redirect_pc
);

    localparam int DEPTH = 1 << ROB_INDEX_BIT;
    localparam int CW    = ROB_INDEX_BIT + 1;
    localparam logic [ROB_INDEX_BIT-1:0] IDX_ONE = ROB_INDEX_BIT'(1);
    localparam logic [CW-1:0]            CNT_ONE = CW'(1);

    logic [ROB_INDEX_BIT-1:0] head_r;
    logic [ROB_INDEX_BIT-1:0] tail_r;
    logic [CW-1:0]            count_r;

    logic [DEPTH-1:0]         busy_r;
    logic [DEPTH-1:0]         ready_r;
    logic [DEPTH-1:0]         is_br_r;
    logic [DEPTH-1:0]         pred_r;
    logic [DEPTH-1:0]         taken_r;
    logic [DEPTH-1:0][4:0]    rd_r;
    logic [DEPTH-1:0][31:0]   val_r;
    logic [DEPTH-1:0][31:0]   target_r;

    logic full_s;
    logic do_commit_s;
    logic mispredict_s;
    logic do_issue_s;
    logic do_wb_s;

    assign full         = full_s;
    assign issue_rob_id = tail_r;

    // Per-cycle decisions; the cycle in which clear is high accepts no issue or writeback
    always_comb begin
        full_s       = (count_r == CW'(DEPTH));
        do_commit_s  = !clear && (count_r != {CW{1'b0}}) && ready_r[head_r];
        mispredict_s = do_commit_s && is_br_r[head_r] && (taken_r[head_r] != pred_r[head_r]);
        do_issue_s   = issue_valid && !full_s && !clear;
        do_wb_s      = wb_valid && !clear && busy_r[wb_rob_id];
    end

    // Operand lookups with same-cycle writeback bypass
    always_comb begin
        qry_ready1 = ready_r[qry_id1];
        qry_val1   = val_r[qry_id1];
        qry_ready2 = ready_r[qry_id2];
        qry_val2   = val_r[qry_id2];
        if (wb_valid && (wb_rob_id == qry_id1)) begin
            qry_ready1 = 1'b1;
            qry_val1   = wb_val;
        end else begin
            qry_ready1 = ready_r[qry_id1];
            qry_val1   = val_r[qry_id1];
        end
        if (wb_valid && (wb_rob_id == qry_id2)) begin
            qry_ready2 = 1'b1;
            qry_val2   = wb_val;
        end else begin
            qry_ready2 = ready_r[qry_id2];
            qry_val2   = val_r[qry_id2];
        end
    end

    // Entry storage, pointers and the registered commit/flush outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_r        <= {ROB_INDEX_BIT{1'b0}};
            tail_r        <= {ROB_INDEX_BIT{1'b0}};
            count_r       <= {CW{1'b0}};
            busy_r        <= {DEPTH{1'b0}};
            ready_r       <= {DEPTH{1'b0}};
            is_br_r       <= {DEPTH{1'b0}};
            pred_r        <= {DEPTH{1'b0}};
            taken_r       <= {DEPTH{1'b0}};
            rd_r          <= {(DEPTH*5){1'b0}};
            val_r         <= {(DEPTH*32){1'b0}};
            target_r      <= {(DEPTH*32){1'b0}};
            commit_rd     <= 5'd0;
            commit_val    <= 32'd0;
            commit_rob_id <= {ROB_INDEX_BIT{1'b0}};
            clear         <= 1'b0;
            redirect_pc   <= 32'd0;
        end else if (rdy_in) begin
            commit_rd <= 5'd0;
            clear     <= 1'b0;
            if (mispredict_s) begin
                // Wrong-path entries are discarded wholesale, including this cycle's issue
                clear         <= 1'b1;
                redirect_pc   <= target_r[head_r];
                commit_val    <= val_r[head_r];
                commit_rob_id <= head_r;
                head_r        <= {ROB_INDEX_BIT{1'b0}};
                tail_r        <= {ROB_INDEX_BIT{1'b0}};
                count_r       <= {CW{1'b0}};
                busy_r        <= {DEPTH{1'b0}};
                ready_r       <= {DEPTH{1'b0}};
            end else begin
                if (do_wb_s) begin
                    ready_r[wb_rob_id]  <= 1'b1;
                    val_r[wb_rob_id]    <= wb_val;
                    taken_r[wb_rob_id]  <= wb_taken;
                    target_r[wb_rob_id] <= wb_target;
                end
                if (do_issue_s) begin
                    busy_r[tail_r]   <= 1'b1;
                    ready_r[tail_r]  <= issue_ready;
                    rd_r[tail_r]     <= issue_rd;
                    is_br_r[tail_r]  <= issue_is_br;
                    pred_r[tail_r]   <= issue_pred_taken;
                    taken_r[tail_r]  <= issue_pred_taken;
                    val_r[tail_r]    <= issue_val;
                    target_r[tail_r] <= 32'd0;
                    tail_r           <= tail_r + IDX_ONE;
                end
                if (do_commit_s) begin
                    busy_r[head_r]  <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    commit_rd       <= is_br_r[head_r] ? 5'd0 : rd_r[head_r];
                    commit_val      <= val_r[head_r];
                    commit_rob_id   <= head_r;
                    head_r          <= head_r + IDX_ONE;
                end
                case ({do_issue_s, do_commit_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule
